// File: rtl/string_hw_avalon_if.sv
// Avalon-MM slave front end for String_HW: packs CPU words into the A/B char
// blocks, runs the go/done handshake and exposes result, status, cycles and irq.
`timescale 1ns/1ps
module string_hw_avalon_if #(
   parameter int MAX_BLOCKS = 2,
   parameter int ADDR_W     = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [ADDR_W-1:0]       address,
   input  logic                    chipselect,
   input  logic                    write,
   input  logic [31:0]             writedata,
   input  logic                    read,
   output logic [31:0]             readdata,
   output logic                    irq,
   output logic                    go,
   output logic [3:0]              index,
   output logic [7:0]              length,
   output logic [MAX_BLOCKS*32-1:0] A,
   output logic [MAX_BLOCKS*32-1:0] B,
   input  logic                    done,
   input  logic [MAX_BLOCKS*32-1:0] Result
);
   localparam int NCH    = MAX_BLOCKS * 4;
   localparam int A_BASE = 3;
   localparam int B_BASE = 3 + MAX_BLOCKS;
   localparam int R_BASE = 3 + 2 * MAX_BLOCKS;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

   state_e                       state_q, state_d;
   logic                         go_q, go_d;
   logic [3:0]                   index_q, index_d;
   logic [7:0]                   length_q, length_d;
   logic                         irq_en_q, irq_en_d;
   logic                         done_sticky_q, done_sticky_d;
   logic                         err_q, err_d;
   logic [31:0]                  cycles_q, cycles_d;
   logic [31:0]                  readdata_q, readdata_d;
   logic [MAX_BLOCKS-1:0][31:0]  a_q, a_d, b_q, b_d, res_q, res_d, res_in;
   logic                         busy, wr_en, rd_en;
   logic                         sticky_set, sticky_clr, err_set, err_clr;
   logic [31:0]                  rdata;

   // String_HW sees char 0 in the most significant byte of its flat vector.
   for (genvar c = 0; c < NCH; c++) begin : g_chars
      assign A[(NCH-1-c)*8 +: 8]        = a_q[c/4][(c%4)*8 +: 8];
      assign B[(NCH-1-c)*8 +: 8]        = b_q[c/4][(c%4)*8 +: 8];
      assign res_in[c/4][(c%4)*8 +: 8]  = Result[(NCH-1-c)*8 +: 8];
   end

   assign busy  = (state_q != IDLE);
   assign wr_en = chipselect & write;
   assign rd_en = chipselect & read;

   always_comb begin
      state_d    = state_q;
      go_d       = go_q;
      index_d    = index_q;
      length_d   = length_q;
      irq_en_d   = irq_en_q;
      cycles_d   = cycles_q;
      a_d        = a_q;
      b_d        = b_q;
      res_d      = res_q;
      sticky_set = 1'b0;
      sticky_clr = 1'b0;
      err_set    = 1'b0;
      err_clr    = 1'b0;

      if (wr_en) begin
         if (address == ADDR_W'(0)) begin
            if (writedata[0] && busy) begin
               err_set = 1'b1;
            end else begin
               irq_en_d = writedata[16];
               if (!busy) begin
                  index_d  = writedata[7:4];
                  length_d = writedata[15:8];
                  if (writedata[0]) begin
                     state_d    = RUN;
                     go_d       = 1'b1;
                     cycles_d   = '0;
                     sticky_clr = 1'b1;
                  end
               end
            end
         end else if (address == ADDR_W'(1)) begin
            sticky_clr = writedata[1];
            err_clr    = writedata[2];
         end
         for (int k = 0; k < MAX_BLOCKS; k++) begin
            if (address == ADDR_W'(A_BASE + k)) begin
               if (busy) err_set = 1'b1;
               else      a_d[k]  = writedata;
            end
            if (address == ADDR_W'(B_BASE + k)) begin
               if (busy) err_set = 1'b1;
               else      b_d[k]  = writedata;
            end
         end
      end

      case (state_q)
         RUN: begin
            if (cycles_q != '1) cycles_d = cycles_q + 32'd1;
            if (done) begin
               res_d   = res_in;
               go_d    = 1'b0;
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            go_d = 1'b0;
            if (!done) begin
               sticky_set = 1'b1;
               state_d    = IDLE;
            end
         end
         default: ;
      endcase

      // A completion landing in the same cycle as a W1C must not be lost.
      done_sticky_d = sticky_set | (done_sticky_q & ~sticky_clr);
      err_d         = err_set | (err_q & ~err_clr);

      rdata = '0;
      if (address == ADDR_W'(0))
         rdata = {15'b0, irq_en_q, length_q, index_q, 3'b0, busy};
      else if (address == ADDR_W'(1))
         rdata = {29'b0, err_q, done_sticky_q, busy};
      else if (address == ADDR_W'(2))
         rdata = cycles_q;
      for (int k = 0; k < MAX_BLOCKS; k++) begin
         if (address == ADDR_W'(A_BASE + k)) rdata = a_q[k];
         if (address == ADDR_W'(B_BASE + k)) rdata = b_q[k];
         if (address == ADDR_W'(R_BASE + k)) rdata = res_q[k];
      end
      readdata_d = rd_en ? rdata : readdata_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         go_q          <= 1'b0;
         index_q       <= '0;
         length_q      <= '0;
         irq_en_q      <= 1'b0;
         done_sticky_q <= 1'b0;
         err_q         <= 1'b0;
         cycles_q      <= '0;
         readdata_q    <= '0;
         a_q           <= '0;
         b_q           <= '0;
         res_q         <= '0;
      end else begin
         state_q       <= state_d;
         go_q          <= go_d;
         index_q       <= index_d;
         length_q      <= length_d;
         irq_en_q      <= irq_en_d;
         done_sticky_q <= done_sticky_d;
         err_q         <= err_d;
         cycles_q      <= cycles_d;
         readdata_q    <= readdata_d;
         a_q           <= a_d;
         b_q           <= b_d;
         res_q         <= res_d;
      end
   end

   assign readdata = readdata_q;
   assign go       = go_q;
   assign index    = index_q;
   assign length   = length_q;
   assign irq      = done_sticky_q & irq_en_q;

endmodule
